// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory/writeback stage.
//   state_t         : FSM states of mem_access_unit
//   fault_t         : fault codes reported on fault_code
//   WORD_ALIGN_MASK : low address bits that must be zero for a word access
//   RD_W            : register index width
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    WB       = 3'd3,
    HALT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_BUS      = 2'd2,
    FLT_TIMEOUT  = 2'd3
  } fault_t;

  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
  localparam int unsigned RD_W            = 5;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Response timeout counter for the WAIT_RSP state.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (request handshake)
//   en         : one waiting cycle elapses
//   expired    : this waiting cycle brings the count to TIMEOUT_CYC
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_count;

  // Count of completed waiting cycles; saturates at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != CNT_W'(TIMEOUT_CYC))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Flags the cycle whose increment reaches TIMEOUT_CYC, so the N-th waiting
  // cycle is the last one and a response in that same cycle can still win.
  assign expired = en && (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory/writeback stage: issues word loads/stores on the data bus and
// produces a one-cycle register-file writeback pulse.
//   in_*/reg_write/mem_*/rd/alu_result/store_data : execute-stage handshake
//   bus_req_*  : request channel (valid/ready)
//   bus_rsp_*  : response channel (always accepted)
//   wb_*       : writeback pulse to the register file
//   fault*     : sticky fault flag, code and faulting address
module mem_access_unit
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [RD_W-1:0]   rd,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] fault_addr
);

  state_t r_state, w_state_nxt;

  // Instruction fields captured on acceptance, plus the load response.
  logic              r_rw, r_mrd, r_mwr, r_m2r;
  logic [RD_W-1:0]   r_rd;
  logic [ADDR_W-1:0] r_alu;
  logic [DATA_W-1:0] r_sdata, r_rdata;
  logic              w_rw_nxt, w_mrd_nxt, w_mwr_nxt, w_m2r_nxt;
  logic [RD_W-1:0]   w_rd_nxt;
  logic [ADDR_W-1:0] w_alu_nxt;
  logic [DATA_W-1:0] w_sdata_nxt, w_rdata_nxt;

  fault_t            r_fault_code, w_code_nxt;
  logic [ADDR_W-1:0] r_fault_addr, w_faddr_nxt;

  logic              r_in_ready, r_req_valid, r_req_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_wb_valid, r_wb_we, r_fault;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic w_accept, w_ctr_clr, w_ctr_en, w_expired;

  bus_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_ctr_clr),
    .en      (w_ctr_en),
    .expired (w_expired)
  );

  // Next-state, capture and fault decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_rw_nxt    = r_rw;
    w_mrd_nxt   = r_mrd;
    w_mwr_nxt   = r_mwr;
    w_m2r_nxt   = r_m2r;
    w_rd_nxt    = r_rd;
    w_alu_nxt   = r_alu;
    w_sdata_nxt = r_sdata;
    w_rdata_nxt = r_rdata;
    w_code_nxt  = r_fault_code;
    w_faddr_nxt = r_fault_addr;
    w_accept    = in_valid && r_in_ready;
    w_ctr_clr   = 1'b0;
    w_ctr_en    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_rw_nxt    = reg_write;
          w_mrd_nxt   = mem_read;
          w_mwr_nxt   = mem_write;
          w_m2r_nxt   = mem_to_reg;
          w_rd_nxt    = rd;
          w_alu_nxt   = alu_result;
          w_sdata_nxt = store_data;
          if (!mem_read && !mem_write) begin
            w_state_nxt = WB;
          end else if ((alu_result[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
            w_state_nxt = HALT;
            w_code_nxt  = FLT_MISALIGN;
            w_faddr_nxt = alu_result;
          end else if (mem_read && mem_write) begin
            w_state_nxt = HALT;
            w_code_nxt  = FLT_TIMEOUT;
            w_faddr_nxt = alu_result;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          w_state_nxt = WAIT_RSP;
          w_ctr_clr   = 1'b1;
        end
      end
      WAIT_RSP: begin
        w_ctr_en = 1'b1;
        // A response always takes priority over the terminal count.
        if (bus_rsp_valid && bus_rsp_err) begin
          w_state_nxt = HALT;
          w_code_nxt  = FLT_BUS;
          w_faddr_nxt = r_alu;
        end else if (bus_rsp_valid) begin
          w_state_nxt = WB;
          w_rdata_nxt = bus_rsp_rdata;
        end else if (w_expired) begin
          w_state_nxt = HALT;
          w_code_nxt  = FLT_TIMEOUT;
          w_faddr_nxt = r_alu;
        end
      end
      WB:      w_state_nxt = IDLE;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured fields and outputs registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rw         <= 1'b0;
      r_mrd        <= 1'b0;
      r_mwr        <= 1'b0;
      r_m2r        <= 1'b0;
      r_rd         <= '0;
      r_alu        <= '0;
      r_sdata      <= '0;
      r_rdata      <= '0;
      r_fault_code <= FLT_NONE;
      r_fault_addr <= '0;
      r_in_ready   <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_we     <= 1'b0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rw         <= w_rw_nxt;
      r_mrd        <= w_mrd_nxt;
      r_mwr        <= w_mwr_nxt;
      r_m2r        <= w_m2r_nxt;
      r_rd         <= w_rd_nxt;
      r_alu        <= w_alu_nxt;
      r_sdata      <= w_sdata_nxt;
      r_rdata      <= w_rdata_nxt;
      r_fault_code <= w_code_nxt;
      r_fault_addr <= w_faddr_nxt;
      r_in_ready   <= (w_state_nxt == IDLE);
      r_req_valid  <= (w_state_nxt == REQ);
      r_req_we     <= (w_state_nxt == REQ) && w_mwr_nxt;
      r_req_addr   <= (w_state_nxt == REQ) ? w_alu_nxt : '0;
      r_req_wdata  <= (w_state_nxt == REQ) ? w_sdata_nxt : '0;
      r_wb_valid   <= (w_state_nxt == WB);
      r_wb_we      <= (w_state_nxt == WB) && w_rw_nxt && (w_rd_nxt != '0);
      r_wb_rd      <= (w_state_nxt == WB) ? w_rd_nxt : '0;
      if (w_state_nxt == WB) begin
        r_wb_data <= (w_mrd_nxt && w_m2r_nxt) ? w_rdata_nxt : DATA_W'(w_alu_nxt);
      end else begin
        r_wb_data <= '0;
      end
      r_fault      <= (w_state_nxt == HALT);
    end
  end

  assign in_ready      = r_in_ready;
  assign bus_req_valid = r_req_valid;
  assign bus_req_we    = r_req_we;
  assign bus_req_addr  = r_req_addr;
  assign bus_req_wdata = r_req_wdata;
  assign wb_valid      = r_wb_valid;
  assign wb_we         = r_wb_we;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign fault         = r_fault;
  assign fault_code    = r_fault_code;
  assign fault_addr    = r_fault_addr;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumes the decoded control word (RegWrite, MemRead, MemWrite, MemtoReg) plus the ALU result, and executes the memory/writeback half of each instruction.
- Issues word loads and stores on the core's data-bus valid/ready request channel, then waits for the response channel.
- Produces a single-cycle writeback pulse to the register file.
- Sits between execute and the register file in each core of the dual-core design. Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data width; word-only access
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT_RSP before a timeout fault; legal range 1..65535

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  unit accepts the instruction this cycle
- reg_write  in  1  decoded RegWrite
- mem_read  in  1  decoded MemRead
- mem_write  in  1  decoded MemWrite
- mem_to_reg  in  1  decoded MemtoReg
- rd  in  5  destination register index
- alu_result  in  ADDR_W  address for memory ops; writeback data otherwise
- store_data  in  DATA_W  rs2 value for stores
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  bus accepts the request
- bus_req_we  out  1  1 = store, 0 = load
- bus_req_addr  out  ADDR_W  word address
- bus_req_wdata  out  DATA_W  store data
- bus_rsp_valid  in  1  response valid (always accepted)
- bus_rsp_rdata  in  DATA_W  load data
- bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  register-file write enable; forced 0 when rd==0
- wb_rd  out  5  destination index
- wb_data  out  DATA_W  writeback value
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout/illegal
- fault_addr  out  ADDR_W  address of the faulting access

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; timeout counter 0; captured fields 0.
- FSM states: IDLE, REQ, WAIT_RSP, WB, HALT.
- in_ready = (state==IDLE). The instruction is accepted on in_valid && in_ready, and all inputs are registered on acceptance.
- IDLE, acceptance of a non-memory op (mem_read==0, mem_write==0): go to WB.
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_we=reg_write&&(rd!=0).
  - Total latency: 1 cycle.
- IDLE, acceptance of a memory op:
  - alu_result[1:0]!=0 -> HALT with code 1. No bus request is issued.
  - mem_read && mem_write both 1 -> HALT with code 3.
  - Otherwise -> REQ.
- REQ: bus_req_valid=1, with address/we/wdata held stable until bus_req_ready. On the handshake go to WAIT_RSP and clear the counter. bus_req_valid must not drop before ready.
- WAIT_RSP: the counter increments every cycle.
  - bus_rsp_valid && !bus_rsp_err -> WB.
  - bus_rsp_valid && bus_rsp_err -> HALT with code 2.
  - Counter reaches TIMEOUT_CYC with no response -> HALT with code 3.
  - A response arriving in the same cycle as the terminal count wins; it is not a timeout.
- WB:
  - Load: wb_data = mem_to_reg ? rsp_rdata : alu_result.
  - Store: wb_we = reg_write&&(rd!=0), normally 0.
  - wb_valid=1 for exactly one cycle, then IDLE.
  - Best-case load/store latency: accept -> REQ (1) -> ready same cycle -> WAIT_RSP -> rsp next cycle -> WB. wb_valid occurs 3 cycles after acceptance.
- HALT: fault=1, and fault_code/fault_addr are held. in_ready=0, no bus activity, no writeback. Only reset leaves HALT.
- A bus_rsp_valid seen outside WAIT_RSP is ignored.
- Reset asserted mid-transaction abandons the transaction immediately. The bus side is responsible for discarding any in-flight response.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state_t enum (IDLE, REQ, WAIT_RSP, WB, HALT)
  - fault_t enum (FLT_NONE, FLT_MISALIGN, FLT_BUS, FLT_TIMEOUT)
  - the WORD_ALIGN_MASK constant
- One sub-module, bus_timeout_ctr:
  - Inputs: clr, en.
  - Output: expired, asserted when the count == TIMEOUT_CYC.
  - Counter width: $clog2(TIMEOUT_CYC+1).

Test Plan:
- Non-memory op: rd=5, alu_result=0x0000_002A, reg_write=1 -> wb_valid 1 cycle later; wb_we=1, wb_rd=5, wb_data=0x2A; bus_req_valid never asserts.
- Load, ready immediate, response 1 cycle later with rdata=0xDEAD_BEEF, addr=0x100, mem_to_reg=1, rd=7 -> bus_req_we=0, bus_req_addr=0x100; wb_data=0xDEAD_BEEF 3 cycles after accept; in_ready low throughout.
- Store, addr=0x204, data=0x1234_5678, ready held low 4 cycles -> request fields stable all 4 cycles; bus_req_we=1; wb_we=0 on the WB pulse.
- Misaligned load, addr=0x102 -> no bus request; fault=1, fault_code=1, fault_addr=0x102; in_ready stays 0.
- Timeout with TIMEOUT_CYC=4, no response -> fault_code=3 after 4 WAIT_RSP cycles. Variant: response on the 4th cycle -> normal WB, no fault.
- Bus error response -> fault_code=2. rd=0 load -> wb_valid=1, wb_we=0. Reset pulse during WAIT_RSP -> all outputs 0, state IDLE, in_ready=1 after reset release.
